// File: rtl/ahb5_pkg.sv
// Shared AHB5 encodings and the master FSM state type.
package ahb5_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_ERR
  } state_e;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/ahb5_addr_gen.sv
// Next-beat address for an incrementing burst and 1 KB boundary crossing flag.
module ahb5_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              cross_1k_o
);

  logic [ADDR_W-1:0] incr;

  assign incr        = ADDR_W'(1) << size_i;
  assign next_addr_o = addr_i + incr;
  // Any change above bit 9 means the next beat lives in another 1 KB page.
  assign cross_1k_o  = (next_addr_o[ADDR_W-1:10] != addr_i[ADDR_W-1:10]);

endmodule

// File: rtl/ahb5_master.sv
// AHB5 command-driven burst master; optional HNONSEC driving via AHB5_NONSEC_EN.
module ahb5_master
  import ahb5_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              HResetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [3:0]        cmd_len,
  input  logic              cmd_nonsec,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HMASTLOCK,
  output logic              HNONSEC,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [3:0]        beats_q, beats_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_last_q, dp_last_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              load_cmd;
  logic [ADDR_W-1:0] next_addr;
  logic              cross_1k;

  ahb5_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr_i      (haddr_q),
    .size_i      (hsize_q),
    .next_addr_o (next_addr),
    .cross_1k_o  (cross_1k)
  );

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    beats_d    = beats_q;
    dp_valid_d = dp_valid_q;
    dp_last_d  = dp_last_q;
    dp_write_d = dp_write_q;
    hwdata_d   = hwdata_q;
    load_cmd   = 1'b0;
    case (state_q)
      ST_IDLE: load_cmd = cmd_valid;
      ST_ACTIVE: begin
        if (dp_valid_q && HRESP && !HREADY) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_ERR;
        end else if (HREADY) begin
          dp_valid_d = 1'b1;
          dp_last_d  = (beats_q == 4'd0);
          dp_write_d = hwrite_q;
          if (hwrite_q) hwdata_d = wr_data;
          if (beats_q == 4'd0) begin
            htrans_d = HTRANS_IDLE;
            state_d  = ST_DRAIN;
          end else begin
            haddr_d  = next_addr;
            htrans_d = cross_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
            beats_d  = beats_q - 4'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (HRESP && !HREADY) begin
          state_d = ST_ERR;
        end else if (HREADY) begin
          dp_valid_d = 1'b0;
          state_d    = ST_IDLE;
          load_cmd   = cmd_valid;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          dp_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A command accepted here goes straight onto the bus as the next address phase.
    if (load_cmd) begin
      state_d  = ST_ACTIVE;
      haddr_d  = cmd_addr;
      htrans_d = HTRANS_NONSEQ;
      hwrite_d = cmd_write;
      hsize_d  = cmd_size;
      hburst_d = (cmd_len == 4'd0) ? HBURST_SINGLE : HBURST_INCR;
      beats_d  = cmd_len;
    end
  end

  always_ff @(posedge Hclk or negedge HResetn) begin
    if (!HResetn) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'd0;
      hburst_q   <= 3'd0;
      beats_q    <= 4'd0;
      dp_valid_q <= 1'b0;
      dp_last_q  <= 1'b0;
      dp_write_q <= 1'b0;
      hwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      beats_q    <= beats_d;
      dp_valid_q <= dp_valid_d;
      dp_last_q  <= dp_last_d;
      dp_write_q <= dp_write_d;
      hwdata_q   <= hwdata_d;
    end
  end

`ifdef AHB5_NONSEC_EN
  logic hnonsec_q;
  always_ff @(posedge Hclk or negedge HResetn) begin
    if (!HResetn)      hnonsec_q <= 1'b0;
    else if (load_cmd) hnonsec_q <= cmd_nonsec;
  end
  assign HNONSEC = hnonsec_q;
`else
  logic unused_nonsec;
  assign unused_nonsec = cmd_nonsec;
  assign HNONSEC       = 1'b0;
`endif

  // cmd_ready is gated by reset because the IDLE state itself would otherwise raise it.
  assign cmd_ready = HResetn && ((state_q == ST_IDLE) || ((state_q == ST_DRAIN) && HREADY));
  assign wr_ready  = (state_q == ST_ACTIVE) && hwrite_q && HREADY;

  assign rsp_valid = dp_valid_q && HREADY;
  assign rsp_err   = rsp_valid && (state_q == ST_ERR);
  assign rsp_last  = rsp_valid && (dp_last_q || (state_q == ST_ERR));
  assign rsp_rdata = (rsp_valid && !dp_write_q) ? HRDATA : '0;

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = hburst_q;
  assign HWDATA    = hwdata_q;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb5_master.sv
// Directed self-checking bench for ahb5_master.
module tb_ahb5_master;

  logic        Hclk = 1'b0;
  logic        HResetn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_nonsec;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HMASTLOCK, HNONSEC;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;
  logic        rsp_valid, rsp_err, rsp_last;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;
  int pulses;
  logic        hr;
  logic [1:0]  exp_trans;
  logic [31:0] exp_addr;
  logic        exp_rsp;

`ifdef AHB5_NONSEC_EN
  localparam logic EXP_NS = 1'b1;
`else
  localparam logic EXP_NS = 1'b0;
`endif

  always #5 Hclk = ~Hclk;

  ahb5_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .Hclk(Hclk), .HResetn(HResetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len), .cmd_nonsec(cmd_nonsec),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK), .HNONSEC(HNONSEC),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = 3'd2;
    cmd_len   = len;
  endtask

  initial begin
    HResetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_len = '0; cmd_nonsec = 1'b1; wr_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    step(); step();
    // Reset state
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_hprot", HPROT, 4'b0011);
    chk("rst_hmastlock", HMASTLOCK, 1'b0);

    // Single write 0x100 / 0xDEADBEEF
    step();
    HResetn = 1'b1;
    issue(1'b1, 32'h100, 4'd0);
    wr_data = 32'hDEADBEEF;
    settle();
    chk("s1_cmd_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    settle();
    chk("s1_htrans", HTRANS, 2'b10);
    chk("s1_haddr", HADDR, 32'h100);
    chk("s1_hburst", HBURST, 3'b000);
    chk("s1_hwrite", HWRITE, 1'b1);
    chk("s1_hsize", HSIZE, 3'd2);
    chk("s1_hnonsec", HNONSEC, EXP_NS);
    chk("s1_wr_ready", wr_ready, 1'b1);
    chk("s1_rsp_early", rsp_valid, 1'b0);
    step();
    wr_data = 32'h0;
    settle();
    chk("s1_hwdata", HWDATA, 32'hDEADBEEF);
    chk("s1_htrans_idle", HTRANS, 2'b00);
    chk("s1_rsp_valid", rsp_valid, 1'b1);
    chk("s1_rsp_last", rsp_last, 1'b1);
    chk("s1_rsp_err", rsp_err, 1'b0);
    step();
    chk("s1_rsp_once", rsp_valid, 1'b0);

    // INCR read of 4 words from 0x200, next command queued in the final data phase
    issue(1'b0, 32'h200, 4'd3);
    settle();
    chk("s2_cmd_ready", cmd_ready, 1'b1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cmd_valid = (i == 4);
      if (i == 4) cmd_addr = 32'h300;
      HRDATA = 32'hA0A0_0000 + i;
      settle();
      if (rsp_valid) pulses++;
      if (i < 4) begin
        chk("s2_htrans", HTRANS, (i == 0) ? 2'b10 : 2'b11);
        chk("s2_haddr", HADDR, 32'h200 + 4 * i);
      end else begin
        chk("s2_htrans_end", HTRANS, 2'b00);
        chk("s2_cmd_ready_drain", cmd_ready, 1'b1);
      end
      if (i == 0) chk("s2_hburst", HBURST, 3'b001);
      chk("s2_rsp_valid", rsp_valid, i > 0);
      if (i > 0) begin
        chk("s2_rdata", rsp_rdata, 32'hA0A0_0000 + i);
        chk("s2_rsp_last", rsp_last, i == 4);
      end
    end
    chk("s2_pulses", pulses, 4);

    // Back-to-back 4-beat read from 0x300 with 2 wait states on beat 2
    for (int c = 0; c < 7; c++) begin
      step();
      cmd_valid = 1'b0;
      hr = !((c == 3) || (c == 4));
      HREADY = hr;
      HRDATA = 32'hB0B0_0000 + c;
      settle();
      exp_trans = (c == 0) ? 2'b10 : ((c <= 5) ? 2'b11 : 2'b00);
      exp_addr  = (c < 3) ? (32'h300 + 4 * c) : 32'h30C;
      exp_rsp   = (c == 1) || (c == 2) || (c == 5) || (c == 6);
      chk("s3_htrans", HTRANS, exp_trans);
      if (c < 6) chk("s3_haddr", HADDR, exp_addr);
      chk("s3_rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp) begin
        chk("s3_rdata", rsp_rdata, 32'hB0B0_0000 + c);
        chk("s3_rsp_last", rsp_last, c == 6);
      end
    end
    HREADY = 1'b1;
    step();
    chk("s3_idle", HTRANS, 2'b00);

    // 4-beat write from 0x3F8 crossing into the next 1 KB page
    issue(1'b1, 32'h3F8, 4'd3);
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      wr_data = 32'hC000_0000 + c;
      settle();
      if (c < 4) begin
        chk("s4_haddr", HADDR, 32'h3F8 + 4 * c);
        chk("s4_htrans", HTRANS, ((c == 0) || (c == 2)) ? 2'b10 : 2'b11);
        chk("s4_wr_ready", wr_ready, 1'b1);
      end
      if (c > 0) chk("s4_hwdata", HWDATA, 32'hC000_0000 + c - 1);
      chk("s4_rsp_last", rsp_last, c == 4);
    end
    step();
    chk("s4_idle", HTRANS, 2'b00);

    // Two-cycle ERROR on beat 1 of a 4-beat read from 0x500
    issue(1'b0, 32'h500, 4'd3);
    step();
    cmd_valid = 1'b0;
    settle();
    chk("s5_htrans0", HTRANS, 2'b10);
    step();
    settle();
    chk("s5_rsp_beat0", rsp_valid, 1'b1);
    chk("s5_err_beat0", rsp_err, 1'b0);
    step();
    HREADY = 1'b0; HRESP = 1'b1;
    settle();
    chk("s5_rsp_err1", rsp_valid, 1'b0);
    chk("s5_htrans_err1", HTRANS, 2'b11);
    step();
    HREADY = 1'b1; HRESP = 1'b1;
    settle();
    chk("s5_htrans_idle", HTRANS, 2'b00);
    chk("s5_rsp_valid", rsp_valid, 1'b1);
    chk("s5_rsp_err", rsp_err, 1'b1);
    chk("s5_rsp_last", rsp_last, 1'b1);
    chk("s5_cmd_ready_err", cmd_ready, 1'b0);
    step();
    HRESP = 1'b0;
    settle();
    chk("s5_no_beats", HTRANS, 2'b00);
    chk("s5_no_rsp", rsp_valid, 1'b0);
    chk("s5_cmd_ready", cmd_ready, 1'b1);
    step();
    chk("s5_still_idle", HTRANS, 2'b00);

    // Reset asserted mid-burst
    issue(1'b1, 32'h600, 4'd3);
    wr_data = 32'h1234_5678;
    step();
    cmd_valid = 1'b0;
    step();
    chk("s6_pre_haddr", HADDR, 32'h604);
    HResetn = 1'b0;
    settle();
    chk("s6_htrans", HTRANS, 2'b00);
    chk("s6_haddr", HADDR, 32'h0);
    chk("s6_hwrite", HWRITE, 1'b0);
    chk("s6_hsize", HSIZE, 3'd0);
    chk("s6_hburst", HBURST, 3'd0);
    chk("s6_hwdata", HWDATA, 32'h0);
    chk("s6_hnonsec", HNONSEC, 1'b0);
    chk("s6_cmd_ready", cmd_ready, 1'b0);
    chk("s6_wr_ready", wr_ready, 1'b0);
    chk("s6_rsp_valid", rsp_valid, 1'b0);
    chk("s6_rsp_rdata", rsp_rdata, 32'h0);
    step();
    HResetn = 1'b1;
    settle();
    chk("s6_cmd_ready_rel", cmd_ready, 1'b1);
    step();
    chk("s6_no_rsp", rsp_valid, 1'b0);
    chk("s6_idle", HTRANS, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb5_master.md
AHB5_MASTER -- requirements
Module: ahb5_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, HADDR/command address width.
REQ-002 SHALL have parameter DATA_W, default 32, data bus width (32 or 64).
REQ-003 SHALL have port Hclk  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port HResetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-007 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  start address.
REQ-009 SHALL have port cmd_size  input  3  HSIZE encoding, at most log2(DATA_W/8).
REQ-010 SHALL have port cmd_len  input  4  beats minus one (0..15).
REQ-011 SHALL have port cmd_nonsec  input  1  requested HNONSEC value.
REQ-012 SHALL have port wr_data  input  DATA_W  write data, sampled one cycle per beat when wr_ready=1.
REQ-013 SHALL have port wr_ready  output  1  write data of the current data-phase beat is consumed.
REQ-014 SHALL have ports HADDR ADDR_W, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HWDATA DATA_W, HMASTLOCK 1, HNONSEC 1, all outputs, AHB5 master signals.
REQ-015 SHALL have ports HRDATA DATA_W, HREADY 1, HRESP 1, all inputs.
REQ-016 SHALL have ports rsp_valid 1, rsp_rdata DATA_W, rsp_err 1, rsp_last 1, all outputs, one pulse per completed data phase.

Function
REQ-017 SHALL implement FSM IDLE, ACTIVE (address phases pending), DRAIN (final data phase only), ERR (second error cycle).
REQ-018 SHALL assert cmd_ready only in IDLE, or in DRAIN when HREADY=1.
REQ-019 SHALL, on acceptance, drive HTRANS=NONSEQ(2'b10) in the next cycle with HADDR=cmd_addr, HBURST=SINGLE(000) if cmd_len=0 else INCR(001).
REQ-020 SHALL drive each subsequent beat as SEQ(2'b11) with HADDR = previous + (1<<HSIZE).
REQ-021 SHALL hold all address-phase outputs stable while HREADY=0.
REQ-022 SHALL drive NONSEQ instead of SEQ when the next beat address crosses a 1 KB boundary.
REQ-023 SHALL drive HWDATA for beat n during its data phase, one cycle after its accepted address phase, held while HREADY=0.
REQ-024 SHALL pulse rsp_valid on each data-phase cycle with HREADY=1, with rsp_rdata=HRDATA for reads, rsp_last=1 on the final beat.
REQ-025 SHALL, on HRESP=1 with HREADY=0, drive HTRANS=IDLE in the following cycle, enter ERR, cancel remaining beats, and report rsp_valid=1, rsp_err=1, rsp_last=1 when HREADY=1.
REQ-026 SHALL drive HTRANS=IDLE(2'b00) whenever no transfer is pending; back-to-back commands SHALL be issued without an IDLE gap.
REQ-027 SHALL drive HPROT=4'b0011 and HMASTLOCK=0 constantly.

Reset
REQ-028 SHALL, while HResetn=0, force HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, HNONSEC=0, cmd_ready=0, wr_ready=0, rsp_valid=0, rsp_err=0, rsp_last=0, rsp_rdata=0, state IDLE.
REQ-029 SHALL discard any in-flight transfer on reset mid-burst, with no response issued.
REQ-030 SHALL raise cmd_ready in the first cycle after reset release.

Configuration
REQ-031 SHALL, with AHB5_NONSEC_EN defined, drive HNONSEC from the latched cmd_nonsec for the whole command.
REQ-032 SHALL, without AHB5_NONSEC_EN, tie HNONSEC to 0 and ignore cmd_nonsec.

Structure
REQ-033 SHALL place the HTRANS, HBURST and HSIZE encodings and the FSM state enum in package ahb5_pkg.
REQ-034 SHALL implement address increment and 1 KB boundary detection in sub-module ahb5_addr_gen.

Verification
REQ-035 SHALL cover: single write addr 0x100, data 0xDEADBEEF, HREADY=1 -> NONSEQ/SINGLE, HWDATA=0xDEADBEEF next cycle, one rsp_valid with rsp_last=1.
REQ-036 SHALL cover: INCR read of 4 words from 0x200 -> HADDR 0x200/0x204/0x208/0x20C with HTRANS N,S,S,S and four rsp_valid pulses.
REQ-037 SHALL cover: 2 wait states on beat 2 -> HADDR/HTRANS held for 2 cycles and rsp_valid suppressed until HREADY=1.
REQ-038 SHALL cover: 4-beat write from 0x3F8 -> beat at 0x400 issued as NONSEQ.
REQ-039 SHALL cover: two-cycle ERROR on beat 1 of a 4-beat burst -> HTRANS=IDLE next cycle, rsp_err=1, rsp_last=1, no further beats.
REQ-040 SHALL cover: HResetn low mid-burst -> all outputs at reset values in the same cycle and cmd_ready=1 after release.
